// File: rtl/game_pkg.sv
// Shared game-mode encodings and button indices used by the sequencer,
// game_logic and the screen renderer.
package game_pkg;

    typedef enum logic [1:0] {
        GM_IDLE  = 2'b00,
        GM_PLAY  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_OVER  = 2'b11
    } gamemode_t;

    localparam int BTN_W     = 3;
    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_ABORT = 2;

    // All-ones so that a button held through reset never counts as a press.
    localparam logic [BTN_W-1:0] BTN_Q_RESET = '1;

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Rising-edge detector for the debounced buttons: press is high for the single
// cycle in which a button level goes from 0 to 1.
module btn_edge
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] btn,
    output logic [BTN_W-1:0] press
);

    logic [BTN_W-1:0] btn_q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q_reg <= BTN_Q_RESET;
        end else begin
            btn_q_reg <= btn;
        end
    end

    generate
        for (genvar gi = 0; gi < BTN_W; gi++) begin : g_edge
            assign press[gi] = btn[gi] & ~btn_q_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/game_sequencer.sv
// Game mode controller: owns idle/play/pause/over, gates the per-frame update
// strobe, pulses map_clear on (re)start and tracks current and best score.
module game_sequencer
    import game_pkg::*;
#(
    parameter int SCORE_W     = 16,
    parameter int SCORE_DIV   = 6,
    parameter int HOLD_FRAMES = 90
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         btn,
    input  logic               frame_tick,
    input  logic               collision,
    output logic [1:0]         gamemode,
    output logic               logic_en,
    output logic               map_clear,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int DIV_W  = $clog2(SCORE_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [BTN_W-1:0] press;

    gamemode_t          state_reg, state_next;
    logic               logic_en_reg, logic_en_next;
    logic               map_clear_reg, map_clear_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] high_score_reg, high_score_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [DIV_W-1:0]   frame_div_reg, frame_div_next;

    logic start_game;
    logic advance;
    logic crash;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= GM_IDLE;
            logic_en_reg   <= 1'b0;
            map_clear_reg  <= 1'b0;
            score_reg      <= '0;
            high_score_reg <= '0;
            hold_cnt_reg   <= '0;
            frame_div_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            logic_en_reg   <= logic_en_next;
            map_clear_reg  <= map_clear_next;
            score_reg      <= score_next;
            high_score_reg <= high_score_next;
            hold_cnt_reg   <= hold_cnt_next;
            frame_div_reg  <= frame_div_next;
        end
    end

    // Transitions; a frame only advances when the game stays in PLAYING.
    always_comb begin
        state_next = state_reg;
        start_game = 1'b0;
        advance    = 1'b0;
        crash      = 1'b0;
        unique case (state_reg)
            GM_IDLE: begin
                if (press[BTN_START]) begin
                    state_next = GM_PLAY;
                    start_game = 1'b1;
                end
            end
            GM_PLAY: begin
                if (collision) begin
                    state_next = GM_OVER;
                    crash      = 1'b1;
                end else if (press[BTN_ABORT]) begin
                    state_next = GM_IDLE;
                end else if (press[BTN_PAUSE]) begin
                    state_next = GM_PAUSE;
                end else begin
                    advance = frame_tick;
                end
            end
            GM_PAUSE: begin
                if (press[BTN_ABORT]) begin
                    state_next = GM_IDLE;
                end else if (press[BTN_PAUSE]) begin
                    state_next = GM_PLAY;
                end
            end
            GM_OVER: begin
                if (hold_cnt_reg == '0) begin
                    if (press[BTN_ABORT]) begin
                        state_next = GM_IDLE;
                    end else if (press[BTN_START]) begin
                        state_next = GM_PLAY;
                        start_game = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        logic_en_next   = advance;
        map_clear_next  = start_game;
        score_next      = score_reg;
        high_score_next = high_score_reg;
        hold_cnt_next   = hold_cnt_reg;
        frame_div_next  = frame_div_reg;

        if (start_game) begin
            score_next     = '0;
            frame_div_next = '0;
        end

        if (advance) begin
            if (frame_div_reg == DIV_LAST) begin
                frame_div_next = '0;
                if (score_reg != SCORE_MAX) begin
                    score_next = score_reg + SCORE_W'(1);
                end
            end else begin
                frame_div_next = frame_div_reg + DIV_W'(1);
            end
        end

        if (crash) begin
            hold_cnt_next = HOLD_INIT;
            if (score_reg > high_score_reg) begin
                high_score_next = score_reg;
            end
        end

        // The hold window counts frames, not clock cycles.
        if (state_reg == GM_OVER && frame_tick && hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
    end

    assign gamemode   = state_reg;
    assign logic_en   = logic_en_reg;
    assign map_clear  = map_clear_reg;
    assign score      = score_reg;
    assign high_score = high_score_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: table-driven opening sequence plus
// hand-written pause, game-over hold, restart, abort and saturation sequences.
module tb_game_sequencer;
    import game_pkg::*;

    typedef struct {
        logic       rst_n;
        logic [2:0] btn;
        logic       tick;
        logic       coll;
        logic [1:0] gm;
        logic       le;
        logic       mc;
        int         score;
        int         hs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  btn = 3'b000;
    logic        frame_tick = 1'b0;
    logic        collision = 1'b0;

    logic [1:0]  gamemode;
    logic        logic_en;
    logic        map_clear;
    logic [15:0] score;
    logic [15:0] high_score;

    logic [1:0]  gamemode4;
    logic        logic_en4;
    logic        map_clear4;
    logic [3:0]  score4;
    logic [3:0]  high_score4;

    vec_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .frame_tick (frame_tick),
        .collision  (collision),
        .gamemode   (gamemode),
        .logic_en   (logic_en),
        .map_clear  (map_clear),
        .score      (score),
        .high_score (high_score)
    );

    game_sequencer #(.SCORE_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .frame_tick (frame_tick),
        .collision  (collision),
        .gamemode   (gamemode4),
        .logic_en   (logic_en4),
        .map_clear  (map_clear4),
        .score      (score4),
        .high_score (high_score4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, and compare after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        rst_n      = v.rst_n;
        btn        = v.btn;
        frame_tick = v.tick;
        collision  = v.coll;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("%s: rst_n=%b btn=%b tick=%b coll=%b -> gm=%b le=%b mc=%b score=%0d hs=%0d",
                 tag, v.rst_n, v.btn, v.tick, v.coll, gamemode, logic_en, map_clear, score, high_score);
        check({tag, ".gamemode"},   32'(gamemode),   32'(e.gm));
        check({tag, ".logic_en"},   32'(logic_en),   32'(e.le));
        check({tag, ".map_clear"},  32'(map_clear),  32'(e.mc));
        check({tag, ".score"},      32'(score),      32'(e.score));
        check({tag, ".high_score"}, 32'(high_score), 32'(e.hs));
    endtask

    task automatic step(input logic r, input logic [2:0] b, input logic t, input logic c,
                        input logic [1:0] gm, input logic le, input logic mc,
                        input int sc, input int hs, input string tag);
        vec_t v;
        v = '{r, b, t, c, gm, le, mc, sc, hs};
        run_vec(v, tag);
    endtask

    initial begin
        vec_t tbl[7];
        // Reset with start held, release, press, first frame.
        tbl[0] = '{1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b1, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 0, 0};
        tbl[4] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0, 0};
        tbl[5] = '{1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 0, 0};
        tbl[6] = '{1'b1, 3'b000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Frames 2..12 of the first game: score = frames / SCORE_DIV.
        for (int i = 2; i <= 12; i++) begin
            step(1, 3'b000, 1, 0, GM_PLAY, 1, 0, i / 6, 0, "run1.tick");
            step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, i / 6, 0, "run1.gap");
        end

        // Pause: ticks and even a collision are ignored.
        step(1, 3'b010, 0, 0, GM_PAUSE, 0, 0, 2, 0, "pause.on");
        step(1, 3'b000, 0, 0, GM_PAUSE, 0, 0, 2, 0, "pause.rel");
        for (int k = 0; k < 5; k++) begin
            step(1, 3'b000, 1, (k == 2), GM_PAUSE, 0, 0, 2, 0, "pause.tick");
            step(1, 3'b000, 0, 0, GM_PAUSE, 0, 0, 2, 0, "pause.gap");
        end
        step(1, 3'b010, 0, 0, GM_PLAY, 0, 0, 2, 0, "pause.off");
        step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, 2, 0, "pause.rel2");

        for (int i = 1; i <= 6; i++) begin
            step(1, 3'b000, 1, 0, GM_PLAY, 1, 0, 2 + i / 6, 0, "run2.tick");
            step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, 2 + i / 6, 0, "run2.gap");
        end

        // Collision, abort and frame tick together: collision wins, no frame.
        step(1, 3'b100, 1, 1, GM_OVER, 0, 0, 3, 3, "crash1");
        step(1, 3'b000, 0, 0, GM_OVER, 0, 0, 3, 3, "crash1.rel");

        // Hold window: start presses ignored until HOLD_FRAMES ticks elapse.
        for (int k = 0; k < 89; k++) begin
            step(1, 3'b000, 1, 0, GM_OVER, 0, 0, 3, 3, "hold1.tick");
            step(1, 3'b001, 0, 0, GM_OVER, 0, 0, 3, 3, "hold1.press");
            step(1, 3'b000, 0, 0, GM_OVER, 0, 0, 3, 3, "hold1.rel");
        end
        step(1, 3'b000, 1, 0, GM_OVER, 0, 0, 3, 3, "hold1.last");
        step(1, 3'b001, 0, 0, GM_PLAY, 0, 1, 0, 3, "restart");
        step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, 0, 3, "restart.rel");

        for (int i = 1; i <= 42; i++) begin
            step(1, 3'b000, 1, 0, GM_PLAY, 1, 0, i / 6, 3, "run3.tick");
            step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, i / 6, 3, "run3.gap");
        end
        step(1, 3'b000, 0, 1, GM_OVER, 0, 0, 7, 7, "crash2");

        for (int k = 0; k < 90; k++) begin
            step(1, 3'b000, 1, 0, GM_OVER, 0, 0, 7, 7, "hold2.tick");
            step(1, 3'b000, 0, 0, GM_OVER, 0, 0, 7, 7, "hold2.gap");
        end
        // Start and abort together after the hold: abort wins, score kept.
        step(1, 3'b101, 0, 0, GM_IDLE, 0, 0, 7, 7, "abort");
        step(1, 3'b000, 0, 0, GM_IDLE, 0, 0, 7, 7, "abort.rel");

        // Long run: 16 * SCORE_DIV frames saturates the 4-bit instance.
        step(1, 3'b001, 0, 0, GM_PLAY, 0, 1, 0, 7, "sat.start");
        step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, 0, 7, "sat.rel");
        for (int i = 1; i <= 96; i++) begin
            step(1, 3'b000, 1, 0, GM_PLAY, 1, 0, i / 6, 7, "sat.tick");
            step(1, 3'b000, 0, 0, GM_PLAY, 0, 0, i / 6, 7, "sat.gap");
        end
        check("sat4.score",    32'(score4),    32'd15);
        check("sat4.gamemode", 32'(gamemode4), 32'(GM_PLAY));
        check("sat4.high",     32'(high_score4), 32'd7);

        // Reset mid-game clears everything including the best score.
        step(0, 3'b000, 0, 0, GM_IDLE, 0, 0, 0, 0, "midrst");
        check("midrst4.score",     32'(score4),      32'd0);
        check("midrst4.high",      32'(high_score4), 32'd0);
        check("midrst4.gamemode",  32'(gamemode4),   32'(GM_IDLE));
        check("midrst4.logic_en",  32'(logic_en4),   32'd0);
        check("midrst4.map_clear", 32'(map_clear4),  32'd0);
        step(1, 3'b000, 1, 0, GM_IDLE, 0, 0, 0, 0, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
